// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, sync-read imem request, one-entry skid buffer, registered output.
// Optional halt detector enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned PC_WIDTH = 10,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         branchTaken,
    input  logic [PC_WIDTH-1:0]          branchTarget,
    output logic [PC_WIDTH-1:0]          imemAddress,
    output logic                         imemRead,
    input  logic [INSTRUCTION_WIDTH-1:0] imemData,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         valid,
    output logic                         halted
);

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic {FETCH, HALTED} state_e;

    state_e                         state_q, state_d;
    logic [PC_WIDTH-1:0]            fetch_pc_q, fetch_pc_d;
    logic                           req_valid_q, req_valid_d;
    logic [PC_WIDTH-1:0]            req_pc_q, req_pc_d;
    logic                           buf_valid_q, buf_valid_d;
    logic [INSTRUCTION_WIDTH-1:0]   buf_instr_q, buf_instr_d;
    logic [PC_WIDTH-1:0]            buf_pc_q, buf_pc_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic                           valid_q, valid_d;
    logic                           halted_q, halted_d;

    logic                           load_valid;
    logic [INSTRUCTION_WIDTH-1:0]   load_instr;
    logic [PC_WIDTH-1:0]            load_pc;
    logic                           halt_hit;
    logic                           issue;

    // Buffered instruction is older than the one returning from memory.
    always_comb begin
        load_valid = 1'b0;
        load_instr = imemData;
        load_pc    = req_pc_q;
        if (buf_valid_q) begin
            load_valid = 1'b1;
            load_instr = buf_instr_q;
            load_pc    = buf_pc_q;
        end else if (req_valid_q) begin
            load_valid = 1'b1;
        end
        halt_hit = HALT_EN && load_valid &&
                   (load_instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_valid_d = req_valid_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        issue       = 1'b0;

        if (branchTaken) begin
            valid_d     = 1'b0;
            req_valid_d = 1'b0;
            buf_valid_d = 1'b0;
            fetch_pc_d  = branchTarget;
            state_d     = FETCH;
            halted_d    = 1'b0;
        end else if (stall) begin
            req_valid_d = 1'b0;
            if (req_valid_q && !buf_valid_q) begin
                buf_valid_d = 1'b1;
                buf_instr_d = imemData;
                buf_pc_d    = req_pc_q;
            end
        end else if (state_q == HALTED) begin
            valid_d     = 1'b0;
            req_valid_d = 1'b0;
            buf_valid_d = 1'b0;
        end else begin
            valid_d     = load_valid;
            if (load_valid) begin
                instr_d = load_instr;
                pc_d    = load_pc;
            end
            buf_valid_d = 1'b0;
            issue       = 1'b1;
            req_valid_d = 1'b1;
            req_pc_d    = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + 1'b1;
            // The read issued alongside a halt is dropped on return.
            if (halt_hit) begin
                state_d     = HALTED;
                halted_d    = 1'b1;
                req_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            instr_q     <= '0;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
        end
    end

    assign imemAddress = fetch_pc_q;
    assign imemRead    = issue & ~reset;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign valid       = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall/skid, branch, wrap, halt.
// Cycle k is the period after the k-th edge following reset release.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branchTaken;
    logic [9:0]  branchTarget;
    logic [9:0]  imemAddress;
    logic        imemRead;
    logic [31:0] imemData = '0;
    logic [31:0] instruction;
    logic [9:0]  pc;
    logic        valid;
    logic        halted;

    logic [31:0] mem [1024];
    int          n_vec = 0;
    int          n_err = 0;

    fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .imemAddress  (imemAddress),
        .imemRead     (imemRead),
        .imemData     (imemData),
        .instruction  (instruction),
        .pc           (pc),
        .valid        (valid),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (imemRead) imemData <= mem[imemAddress];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [9:0] t);
        stall        = s;
        branchTaken  = b;
        branchTarget = t;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v,
                              input logic [9:0] p, input logic [31:0] ins);
        check({tag, "_valid"}, {31'b0, valid}, {31'b0, v});
        if (v) begin
            check({tag, "_pc"}, {22'b0, pc}, {22'b0, p});
            check({tag, "_instr"}, instruction, ins);
        end
    endtask

    // Leaves the bench at cycle 0 (first edge with reset low just taken).
    task automatic do_reset();
        drive(1'b0, 1'b0, 10'h0);
        reset = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_pc", {22'b0, pc}, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_read", {31'b0, imemRead}, 32'h0);
        reset = 1'b0;
        #1;
        check("rel_read", {31'b0, imemRead}, 32'h1);
        check("rel_addr", {22'b0, imemAddress}, 32'h0);
        tick();
    endtask

    initial begin
        logic [9:0] wrap_pc [4];
        wrap_pc[0] = 10'h3FE;
        wrap_pc[1] = 10'h3FF;
        wrap_pc[2] = 10'h000;
        wrap_pc[3] = 10'h001;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

        // Streaming after reset
        do_reset();
        check("a_c0_valid", {31'b0, valid}, 32'h0);
        check("a_c0_addr", {22'b0, imemAddress}, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            expect_out("a_stream", 1'b1, 10'(k - 1), 32'h1000_0000 + k - 1);
            check("a_read", {31'b0, imemRead}, 32'h1);
            check("a_addr", {22'b0, imemAddress}, k + 1);
        end

        // Stall for three cycles while pc=2 is presented
        do_reset();
        tick(); tick(); tick();
        for (int k = 3; k <= 6; k++) begin
            if (k > 3) tick();
            if (k == 3) drive(1'b1, 1'b0, 10'h0);
            if (k == 6) drive(1'b0, 1'b0, 10'h0);
            expect_out("b_hold", 1'b1, 10'd2, 32'h1000_0002);
            check("b_addr", {22'b0, imemAddress}, 32'h4);
            check("b_read", {31'b0, imemRead}, (k == 6) ? 32'h1 : 32'h0);
        end
        tick();
        expect_out("b_after3", 1'b1, 10'd3, 32'h1000_0003);
        tick();
        expect_out("b_after4", 1'b1, 10'd4, 32'h1000_0004);

        // Branch to 0x3F0, then to 0x3FE with wrap
        do_reset();
        for (int k = 1; k <= 6; k++) tick();
        expect_out("c_pre", 1'b1, 10'd5, 32'h1000_0005);
        drive(1'b0, 1'b1, 10'h3F0);
        check("c_br_read", {31'b0, imemRead}, 32'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0);
        expect_out("c_bub1", 1'b0, 10'h0, 32'h0);
        check("c_tgt_read", {31'b0, imemRead}, 32'h1);
        check("c_tgt_addr", {22'b0, imemAddress}, 32'h3F0);
        tick();
        expect_out("c_bub2", 1'b0, 10'h0, 32'h0);
        tick();
        expect_out("c_tgt", 1'b1, 10'h3F0, 32'h1000_03F0);
        tick();
        expect_out("c_tgt1", 1'b1, 10'h3F1, 32'h1000_03F1);
        drive(1'b0, 1'b1, 10'h3FE);
        tick();
        drive(1'b0, 1'b0, 10'h0);
        expect_out("d_bub1", 1'b0, 10'h0, 32'h0);
        tick();
        expect_out("d_bub2", 1'b0, 10'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_out("d_wrap", 1'b1, wrap_pc[k], 32'h1000_0000 + wrap_pc[k]);
        end

        // Stall and branch together with the skid buffer full
        do_reset();
        tick(); tick(); tick();
        drive(1'b1, 1'b0, 10'h0);
        tick();
        expect_out("e_stalled", 1'b1, 10'd2, 32'h1000_0002);
        drive(1'b1, 1'b1, 10'h020);
        check("e_br_read", {31'b0, imemRead}, 32'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0);
        expect_out("e_bub1", 1'b0, 10'h0, 32'h0);
        tick();
        expect_out("e_bub2", 1'b0, 10'h0, 32'h0);
        tick();
        expect_out("e_tgt", 1'b1, 10'h020, 32'h1000_0020);
        tick();
        expect_out("e_tgt1", 1'b1, 10'h021, 32'h1000_0021);

        // Halt opcode at address 3
        mem[3] = 32'hF000_0000;
        do_reset();
        for (int k = 1; k <= 4; k++) tick();
`ifdef FETCH_HALT_DETECT_EN
        expect_out("f_halt", 1'b1, 10'd3, 32'hF000_0000);
        check("f_halted", {31'b0, halted}, 32'h1);
        check("f_read0", {31'b0, imemRead}, 32'h0);
        drive(1'b1, 1'b0, 10'h0);
        tick();
        expect_out("f_hold", 1'b1, 10'd3, 32'hF000_0000);
        drive(1'b0, 1'b0, 10'h0);
        tick();
        expect_out("f_off1", 1'b0, 10'h0, 32'h0);
        check("f_halted1", {31'b0, halted}, 32'h1);
        check("f_read1", {31'b0, imemRead}, 32'h0);
        tick();
        expect_out("f_off2", 1'b0, 10'h0, 32'h0);
        check("f_read2", {31'b0, imemRead}, 32'h0);
        drive(1'b0, 1'b1, 10'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0);
        check("f_unhalt", {31'b0, halted}, 32'h0);
        check("f_rd_res", {31'b0, imemRead}, 32'h1);
        check("f_addr_res", {22'b0, imemAddress}, 32'h0);
        tick();
        expect_out("f_bub", 1'b0, 10'h0, 32'h0);
        tick();
        expect_out("f_resume", 1'b1, 10'h0, 32'h1000_0000);
`else
        expect_out("f_plain", 1'b1, 10'd3, 32'hF000_0000);
        check("f_nohalt", {31'b0, halted}, 32'h0);
        check("f_read", {31'b0, imemRead}, 32'h1);
        tick();
        expect_out("f_next", 1'b1, 10'd4, 32'h1000_0004);
        check("f_nohalt1", {31'b0, halted}, 32'h0);
`endif
        mem[3] = 32'h1000_0003;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
